// File: rtl/parity_mem_ctrl.sv
// parity_mem_ctrl: single-port memory storing each word with an even-parity bit.
// Tracks written/unwritten words, checks parity on read, counts read/write
// collisions and parity errors with saturating counters. Read latency RD_LAT
// (1..4) is built from a registered array read followed by RD_LAT-1 stages.
// Optional feature macro: PARITY_MEM_ERR_INJECT_EN (adds err_inject input that
// inverts the stored parity bit on an accepted write).
module parity_mem_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic              read,
`ifdef PARITY_MEM_ERR_INJECT_EN
  input  logic              err_inject,
`endif
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W:0]   data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              collision,
  output logic [CNT_W-1:0]  collision_count,
  output logic [CNT_W-1:0]  perr_count
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int WORD_W = DATA_W + 1;

  // Parity inversion request; tied off when the injection feature is absent.
  logic inject;
`ifdef PARITY_MEM_ERR_INJECT_EN
  assign inject = err_inject;
`else
  assign inject = 1'b0;
`endif

  // Strobe decode. Writes always win; a simultaneous read is dropped.
  logic wr_en;
  logic rd_accept;
  logic coll_evt;
  assign wr_en     = write & ~reset;
  assign rd_accept = read & ~write & ~reset;
  assign coll_evt  = read & write & ~reset;

  // Stored word: {even parity (optionally inverted), data}.
  logic [WORD_W-1:0] wr_word;
  assign wr_word = {(^data_in) ^ inject, data_in};

  // Storage and read-data pipeline. Data words carry no reset: they are only
  // observed when the matching valid bit (which is reset) is set.
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] word_pipe_q [RD_LAT];

  // Per-word written flags, valid/written-flag pipeline, pulse and counters.
  logic [DEPTH-1:0]  written_q, written_d;
  logic [RD_LAT-1:0] valid_q, valid_d;
  logic [RD_LAT-1:0] wflag_q, wflag_d;
  logic              collision_q, collision_d;
  logic [CNT_W-1:0]  coll_cnt_q, coll_cnt_d;
  logic [CNT_W-1:0]  perr_cnt_q, perr_cnt_d;

  // Final pipeline stage decode.
  logic [WORD_W-1:0] out_word;
  logic              out_live;
  logic              out_perr;
  assign out_word = word_pipe_q[RD_LAT-1];
  assign out_live = valid_q[RD_LAT-1] & wflag_q[RD_LAT-1];
  assign out_perr = out_live & (^out_word);

  // Array write, registered array read, and data shift through later stages.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[address] <= wr_word;
    end
    if (rd_accept) begin
      word_pipe_q[0] <= mem[address];
    end
    for (int i = 1; i < RD_LAT; i++) begin
      word_pipe_q[i] <= word_pipe_q[i-1];
    end
  end

  // Next-state for written flags, read pipeline qualifiers and counters.
  always_comb begin
    written_d = written_q;
    if (wr_en) begin
      written_d[address] = 1'b1;
    end

    valid_d    = '0;
    wflag_d    = '0;
    valid_d[0] = rd_accept;
    wflag_d[0] = written_q[address];
    for (int i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      wflag_d[i] = wflag_q[i-1];
    end

    collision_d = coll_evt;

    coll_cnt_d = coll_cnt_q;
    if (coll_evt && (coll_cnt_q != {CNT_W{1'b1}})) begin
      coll_cnt_d = coll_cnt_q + 1'b1;
    end

    perr_cnt_d = perr_cnt_q;
    if (out_perr && (perr_cnt_q != {CNT_W{1'b1}})) begin
      perr_cnt_d = perr_cnt_q + 1'b1;
    end
  end

  // Control state registers; reset flushes in-flight reads and clears flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      written_q   <= '0;
      valid_q     <= '0;
      wflag_q     <= '0;
      collision_q <= 1'b0;
      coll_cnt_q  <= '0;
      perr_cnt_q  <= '0;
    end else begin
      written_q   <= written_d;
      valid_q     <= valid_d;
      wflag_q     <= wflag_d;
      collision_q <= collision_d;
      coll_cnt_q  <= coll_cnt_d;
      perr_cnt_q  <= perr_cnt_d;
    end
  end

  // Unwritten words read back as zero with no parity error.
  assign data_out        = out_live ? out_word : '0;
  assign data_valid      = valid_q[RD_LAT-1];
  assign parity_err      = out_perr;
  assign collision       = collision_q;
  assign collision_count = coll_cnt_q;
  assign perr_count      = perr_cnt_q;

endmodule

// File: doc/parity_mem_ctrl.md
Name: parity_mem_ctrl

Overview:
- Parametrised single-port memory block. Each word is stored together with an even-parity bit.
- Replaces the fixed 8-bit data / 16-bit address memory interface. Adds the following:
  - configurable widths and read latency
  - per-word written/unwritten tracking
  - parity checking on read
  - saturating counters for read/write collisions and parity errors
- Sits between a testbench or bus driver and the storage array. It is the DUT-side endpoint of the memory channel.

Parameters:
- DATA_W, 8, data width in bits. data_out is DATA_W+1 bits wide.
- ADDR_W, 8, address width. Depth is 2**ADDR_W words.
- RD_LAT, 1, read latency in clock edges. Legal range is 1 to 4.
- CNT_W, 16, width of the saturating event counters.

Ports:
- clk  input  1  clock. All logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- write  input  1  write strobe.
- read  input  1  read strobe.
- data_in  input  DATA_W  write data.
- address  input  ADDR_W  word address for read or write.
- data_out  output  DATA_W+1  {parity, data} of the returned word.
- data_valid  output  1  one-cycle qualifier for data_out.
- parity_err  output  1  one-cycle pulse, aligned with data_valid, flagging a parity mismatch.
- collision  output  1  one-cycle pulse when write and read are sampled high together.
- collision_count  output  CNT_W  saturating collision count.
- perr_count  output  CNT_W  saturating parity-error count.

Behaviour:
- Even parity:
  - stored bit p = XOR of all bits of the data word.
  - {p, data} always contains an even number of ones.
- Reset (sync, edge where reset is sampled high):
  - data_out=0, data_valid=0, parity_err=0, collision=0.
  - both counters = 0.
  - read pipeline flushed.
  - all per-word written flags cleared.
  - Array contents are not cleared.
  - A read or write launched before reset never produces data_valid after it. This applies to reset mid-pipeline.
- Write (write=1, read=0 at edge N):
  - array[address] <= {p, data_in}.
  - written[address] <= 1.
- Read (read=1, write=0 at edge N):
  - data_out and data_valid are updated at edge N+RD_LAT-1 and are visible after it, i.e. RD_LAT edges after the request.
  - data_valid is high for exactly one cycle per accepted read.
  - Back-to-back reads on consecutive cycles are fully pipelined: one result per cycle, in order.
- Read after write: a write at edge N followed by a read of the same address at edge N+1 returns the new data.
- Unwritten word:
  - data_out = 0, data_valid = 1, parity_err = 0.
  - counters are unchanged.
- Parity check on read:
  - recompute XOR of the stored data and compare it with the stored p.
  - On mismatch, parity_err pulses together with data_valid and perr_count increments.
- Collision (write=1 and read=1 at the same edge):
  - the write is performed; the read is dropped (no data_valid is ever issued for it).
  - collision pulses high for the following cycle.
  - collision_count increments.
- Counters:
  - both saturate at 2**CNT_W-1 and never wrap.
  - They clear only on reset.
- Strobes low: no state change; data_valid stays 0.
- Address range: every address is in range (full 2**ADDR_W depth). There is no wrap logic.

Optional Feature:
- Macro: PARITY_MEM_ERR_INJECT_EN.
- When defined:
  - adds input port err_inject (1 bit).
  - If err_inject=1 on an accepted write (including a collision write), the stored parity bit is inverted. A later read of that word then yields parity_err=1.
  - err_inject is ignored on reads and idle cycles.
- When not defined:
  - the port is absent and stored parity is always correct.
  - parity_err can only assert through array corruption, so it is 0 in all directed tests.

Test Plan:
- Reset, then read address 0x05 → after RD_LAT edges: data_valid=1, data_out=0, parity_err=0. Both counters read 0.
- Write 0xA5 to 0x10, then read 0x10 on the next cycle → data_out=0x0A5 (four ones, p=0). Write 0x07 to 0x11 and read it → data_out=0x107.
- RD_LAT=3: reads to 0x10, 0x11, 0x12 on three consecutive cycles → three consecutive data_valid pulses, in order, starting 3 edges after the first read.
- write=1 and read=1 together, data 0x3C to 0x20 → collision pulses, collision_count=1, no data_valid. A later read of 0x20 returns 0x03C. Force 2**CNT_W+2 collisions with CNT_W=4 → collision_count holds at 15.
- PARITY_MEM_ERR_INJECT_EN: write 0xFF to 0x30 with err_inject=1, then read 0x30 → data_out=0x1FF, parity_err=1, perr_count=1.
- Read issued with RD_LAT=4, reset asserted 2 cycles later → no data_valid after reset, all outputs 0, and the written flags are cleared (a read of 0x10 returns 0).
